// File: rtl/sdram_burst_arbiter_if.sv
// rtl/sdram_burst_arbiter_if.sv - burst request/ack/done handshake between the arbiter and the SDRAM command controller
interface sdram_burst_arbiter_if #(
  parameter int ADDR_W = 24
);
  logic              sdr_req;
  logic              sdr_wr;
  logic [ADDR_W-1:0] sdr_addr;
  logic              sdr_ack;
  logic              sdr_done;

  modport master (
    output sdr_req,
    output sdr_wr,
    output sdr_addr,
    input  sdr_ack,
    input  sdr_done
  );

  modport slave (
    input  sdr_req,
    input  sdr_wr,
    input  sdr_addr,
    output sdr_ack,
    output sdr_done
  );
endinterface

// File: rtl/sdram_burst_arbiter.sv
// rtl/sdram_burst_arbiter.sv - SDRAM ring-buffer burst arbiter between the write-side and read-side FIFOs
// Optional outstanding-burst watchdog is enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_burst_arbiter #(
  parameter int ADDR_W      = 24,
  parameter int CNT_W       = 10,
  parameter int BURST_LEN   = 8,
  parameter int RFIFO_DEPTH = 512,
  parameter int RING_BURSTS = 1024,
  parameter int BASE_ADDR   = 0,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         init_done,
  input  logic                         rd_enable,
  input  logic [CNT_W-1:0]             wfifo_count,
  input  logic [CNT_W-1:0]             rfifo_count,
  sdram_burst_arbiter_if.master        sdr,
  output logic [$clog2(RING_BURSTS):0] ring_level,
  output logic                         ring_full,
  output logic                         ring_empty,
  output logic                         err
);

  localparam int IDX_W = (RING_BURSTS > 1) ? $clog2(RING_BURSTS) : 1;
  localparam int LVL_W = $clog2(RING_BURSTS) + 1;
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(RING_BURSTS);
  localparam logic [31:0]      BL_U    = 32'(BURST_LEN);
  localparam logic [31:0]      DEPTH_U = 32'(RFIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    RD_REQ,
    RD_WAIT
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              last_grant_wr;

  logic [31:0]       wcnt_ext;
  logic [31:0]       rcnt_ext;
  logic              wr_ok;
  logic              rd_ok;
  logic              grant_wr;
  logic              is_wr;
  logic              burst_done;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int WDOG_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);
  logic [WDOG_W-1:0] wait_cnt;
`endif

  // Read needs room for a whole burst in the read-side FIFO; a count above depth blocks reads.
  always_comb begin
    wcnt_ext = 32'(wfifo_count);
    rcnt_ext = 32'(rfifo_count);
    wr_ok    = init_done && (wcnt_ext >= BL_U) && !ring_full;
    rd_ok    = init_done && rd_enable && !ring_empty &&
               (rcnt_ext <= DEPTH_U) && ((DEPTH_U - rcnt_ext) >= BL_U);
    grant_wr = wr_ok && (!rd_ok || !last_grant_wr);
  end

  assign wr_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(wr_idx) * ADDR_W'(BURST_LEN);
  assign rd_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(rd_idx) * ADDR_W'(BURST_LEN);

  assign is_wr      = (state == WR_REQ) || (state == WR_WAIT);
  assign burst_done = (((state == WR_REQ) || (state == RD_REQ)) && sdr.sdr_ack && sdr.sdr_done) ||
                      (((state == WR_WAIT) || (state == RD_WAIT)) && sdr.sdr_done);

`ifndef SDRAM_ARB_TIMEOUT_EN
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      sdr.sdr_req   <= 1'b0;
      sdr.sdr_wr    <= 1'b0;
      sdr.sdr_addr  <= ADDR_W'(BASE_ADDR);
      wr_idx        <= '0;
      rd_idx        <= '0;
      ring_level    <= '0;
      ring_empty    <= 1'b1;
      ring_full     <= 1'b0;
      last_grant_wr <= 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      err           <= 1'b0;
      wait_cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (wr_ok || rd_ok) begin
            sdr.sdr_req  <= 1'b1;
            sdr.sdr_wr   <= grant_wr;
            sdr.sdr_addr <= grant_wr ? wr_addr : rd_addr;
            state        <= grant_wr ? WR_REQ : RD_REQ;
          end
        end
        WR_REQ, RD_REQ: begin
          if (sdr.sdr_ack) begin
            sdr.sdr_req <= 1'b0;
            state       <= (state == WR_REQ) ? WR_WAIT : RD_WAIT;
`ifdef SDRAM_ARB_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
          end
        end
        WR_WAIT, RD_WAIT: begin
`ifdef SDRAM_ARB_TIMEOUT_EN
          // Abandoned burst: ring bookkeeping stays untouched so the slot is retried.
          if (!sdr.sdr_done) begin
            if (wait_cnt == WDOG_LAST) begin
              err   <= 1'b1;
              state <= IDLE;
            end else begin
              wait_cnt <= wait_cnt + WDOG_W'(1);
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase

      // Completion overrides the state chosen above, including ack+done in one cycle.
      if (burst_done) begin
        state         <= IDLE;
        last_grant_wr <= is_wr;
        if (is_wr) begin
          wr_idx     <= wr_idx + IDX_W'(1);
          ring_level <= ring_level + LVL_W'(1);
          ring_empty <= 1'b0;
          ring_full  <= (ring_level == (LVL_MAX - LVL_W'(1)));
        end else begin
          rd_idx     <= rd_idx + IDX_W'(1);
          ring_level <= ring_level - LVL_W'(1);
          ring_full  <= 1'b0;
          ring_empty <= (ring_level == LVL_W'(1));
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// tb/tb_sdram_burst_arbiter.sv - self-checking bench for sdram_burst_arbiter with a queue-based ring model
module tb_sdram_burst_arbiter;

  localparam int AW    = 24;
  localparam int CW    = 10;
  localparam int BL    = 8;
  localparam int DEPTH = 512;
  localparam int RING  = 4;
  localparam int TMO   = 30;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_done;
  logic          rd_enable;
  logic [CW-1:0] wfifo_count;
  logic [CW-1:0] rfifo_count;
  logic [2:0]    ring_level;
  logic          ring_full;
  logic          ring_empty;
  logic          err;

  sdram_burst_arbiter_if #(.ADDR_W(AW)) sdr ();

  sdram_burst_arbiter #(
    .ADDR_W(AW), .CNT_W(CW), .BURST_LEN(BL), .RFIFO_DEPTH(DEPTH),
    .RING_BURSTS(RING), .BASE_ADDR(0), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .rd_enable(rd_enable),
    .wfifo_count(wfifo_count), .rfifo_count(rfifo_count), .sdr(sdr),
    .ring_level(ring_level), .ring_full(ring_full), .ring_empty(ring_empty), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference ring: queue of burst addresses currently stored in SDRAM.
  logic [AW-1:0] ring_q[$];
  int            m_wr_idx;
  bit            m_last_wr;

  function automatic void model_clear();
    ring_q.delete();
    m_wr_idx  = 0;
    m_last_wr = 0;
  endfunction

  // 0 = no grant, 1 = write, 2 = read
  function automatic void predict(output int eg, output logic [AW-1:0] ea);
    bit w_ok, r_ok;
    w_ok = init_done && (int'(wfifo_count) >= BL) && (ring_q.size() < RING);
    r_ok = init_done && rd_enable && (ring_q.size() > 0) && (int'(rfifo_count) + BL <= DEPTH);
    ea = '0;
    eg = 0;
    if (w_ok && (!r_ok || !m_last_wr)) begin
      eg = 1;
      ea = AW'(m_wr_idx * BL);
    end else if (r_ok) begin
      eg = 2;
      ea = ring_q[0];
    end
  endfunction

  function automatic void model_commit(input int eg, input logic [AW-1:0] ea);
    if (eg == 1) begin
      ring_q.push_back(ea);
      m_wr_idx  = (m_wr_idx + 1) % RING;
      m_last_wr = 1;
    end else if (eg == 2) begin
      void'(ring_q.pop_front());
      m_last_wr = 0;
    end
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    sdr.sdr_ack  = 1'b0;
    sdr.sdr_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // Acts as the SDRAM controller for one burst; returns what was observed.
  task automatic do_burst(input int ack_dly, input int done_dly, output bit got, output int og,
                          output logic [AW-1:0] addr, output int lat, output bit stable);
    logic wr;
    got = 0; stable = 1; lat = 0; addr = '0; og = 0; wr = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (sdr.sdr_req) got = 1;
    end
    if (got) begin
      wr   = sdr.sdr_wr;
      addr = sdr.sdr_addr;
      og   = wr ? 1 : 2;
      for (int i = 0; i < ack_dly; i++) begin
        @(negedge clk);
        if (!sdr.sdr_req || sdr.sdr_wr !== wr || sdr.sdr_addr !== addr) stable = 0;
      end
      sdr.sdr_ack = 1'b1;
      if (done_dly == 0) sdr.sdr_done = 1'b1;
      @(negedge clk);
      sdr.sdr_ack  = 1'b0;
      sdr.sdr_done = 1'b0;
      if (sdr.sdr_req) stable = 0;
      if (done_dly > 0) begin
        repeat (done_dly - 1) @(negedge clk);
        sdr.sdr_done = 1'b1;
        @(negedge clk);
        sdr.sdr_done = 1'b0;
      end
    end
  endtask

  task automatic idle_cycles(input int n, output bit seen);
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (sdr.sdr_req) seen = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; init_done = 1'b1; rd_enable = 1'b1;
    wfifo_count = 10'd64; rfifo_count = '0;
    sdr.sdr_ack = 1'b0; sdr.sdr_done = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (sdr.sdr_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%b exp=0", sdr.sdr_req); end
    n_cmp++; if (sdr.sdr_wr !== 1'b0) begin n_bad++; $display("FAIL reset_wr got=%b exp=0", sdr.sdr_wr); end
    n_cmp++; if (sdr.sdr_addr !== 24'd0) begin n_bad++; $display("FAIL reset_addr got=%0d exp=0", sdr.sdr_addr); end
    n_cmp++; if (ring_level !== 3'd0) begin n_bad++; $display("FAIL reset_level got=%0d exp=0", ring_level); end
    n_cmp++; if (ring_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got=%b exp=1", ring_empty); end
    n_cmp++; if (ring_full !== 1'b0) begin n_bad++; $display("FAIL reset_full got=%b exp=0", ring_full); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_init_gate();
    bit seen;
    init_done = 1'b0; wfifo_count = 10'd64; rd_enable = 1'b1;
    idle_cycles(5, seen);
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL init_gate req_seen=%b exp=0", seen); end
  endtask

  task automatic test_single_write();
    bit got, stable; int og, lat; logic [AW-1:0] addr;
    init_done = 1'b1; wfifo_count = 10'd8; rd_enable = 1'b0;
    do_burst(1, 2, got, og, addr, lat, stable);
    n_cmp++; if (og !== 1) begin n_bad++; $display("FAIL sw1_kind got=%0d exp=1", og); end
    n_cmp++; if (addr !== 24'd0) begin n_bad++; $display("FAIL sw1_addr got=%0d exp=0", addr); end
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL sw1_latency got=%0d exp=1", lat); end
    n_cmp++; if (stable !== 1'b1) begin n_bad++; $display("FAIL sw1_hold got=%b exp=1", stable); end
    n_cmp++; if (ring_level !== 3'd1 || ring_empty !== 1'b0) begin
      n_bad++; $display("FAIL sw1_level got=%0d/%b exp=1/0", ring_level, ring_empty); end
    model_commit(1, 24'd0);
    do_burst(0, 0, got, og, addr, lat, stable);
    n_cmp++; if (og !== 1 || addr !== 24'd8) begin n_bad++; $display("FAIL sw2_addr got=%0d/%0d exp=1/8", og, addr); end
    n_cmp++; if (ring_level !== 3'd2) begin n_bad++; $display("FAIL sw2_level got=%0d exp=2", ring_level); end
    model_commit(1, 24'd8);
    wfifo_count = '0;
  endtask

  task automatic test_contention();
    // ring holds bursts 0,8, last grant was a write: expect R0, W16, R8, W24
    int exp_k[4] = '{2, 1, 2, 1};
    logic [AW-1:0] exp_a[4] = '{24'd0, 24'd16, 24'd8, 24'd24};
    int exp_l[4] = '{1, 2, 1, 2};
    bit got, stable; int og, lat; logic [AW-1:0] addr;
    wfifo_count = 10'd16; rd_enable = 1'b1; rfifo_count = '0;
    for (int k = 0; k < 4; k++) begin
      do_burst(k % 3, k % 2, got, og, addr, lat, stable);
      n_cmp++; if (og !== exp_k[k] || addr !== exp_a[k]) begin
        n_bad++; $display("FAIL contention[%0d] got=%0d@%0d exp=%0d@%0d", k, og, addr, exp_k[k], exp_a[k]); end
      n_cmp++; if (ring_level !== 3'(exp_l[k])) begin
        n_bad++; $display("FAIL contention_level[%0d] got=%0d exp=%0d", k, ring_level, exp_l[k]); end
      model_commit(exp_k[k], exp_a[k]);
    end
  endtask

  task automatic test_wrap_full();
    bit got, stable, seen; int og, lat; logic [AW-1:0] addr;
    apply_reset();
    init_done = 1'b1; wfifo_count = 10'd64; rd_enable = 1'b0; rfifo_count = '0;
    for (int k = 0; k < 4; k++) begin
      do_burst(0, 1, got, og, addr, lat, stable);
      n_cmp++; if (og !== 1 || addr !== AW'(k * BL)) begin
        n_bad++; $display("FAIL fill[%0d] got=%0d@%0d exp=1@%0d", k, og, addr, k * BL); end
      model_commit(1, AW'(k * BL));
    end
    n_cmp++; if (ring_full !== 1'b1 || ring_level !== 3'd4) begin
      n_bad++; $display("FAIL full_flag got=%b/%0d exp=1/4", ring_full, ring_level); end
    idle_cycles(6, seen);
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL no_fifth_write req_seen=%b exp=0", seen); end
    rd_enable = 1'b1; wfifo_count = '0;
    do_burst(1, 1, got, og, addr, lat, stable);
    n_cmp++; if (og !== 2 || addr !== 24'd0) begin n_bad++; $display("FAIL wrap_read got=%0d@%0d exp=2@0", og, addr); end
    model_commit(2, 24'd0);
    rd_enable = 1'b0; wfifo_count = 10'd64;
    do_burst(0, 0, got, og, addr, lat, stable);
    n_cmp++; if (og !== 1 || addr !== 24'd0) begin n_bad++; $display("FAIL wrap_write got=%0d@%0d exp=1@0", og, addr); end
    model_commit(1, 24'd0);
  endtask

  task automatic test_read_gating();
    bit got, stable, seen; int og, lat; logic [AW-1:0] addr;
    wfifo_count = '0; rd_enable = 1'b1; rfifo_count = CW'(DEPTH - 7);
    idle_cycles(5, seen);
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL read_gate_7 req_seen=%b exp=0", seen); end
    rfifo_count = CW'(DEPTH - 8);
    do_burst(2, 1, got, og, addr, lat, stable);
    n_cmp++; if (og !== 2 || addr !== 24'd8 || lat !== 1) begin
      n_bad++; $display("FAIL read_gate_8 got=%0d@%0d lat=%0d exp=2@8 lat=1", og, addr, lat); end
    n_cmp++; if (ring_level !== 3'd3) begin n_bad++; $display("FAIL read_gate_level got=%0d exp=3", ring_level); end
    model_commit(2, 24'd8);
  endtask

  task automatic test_back_to_back();
    bit got, stable; int og, lat, eg; logic [AW-1:0] addr, ea;
    wfifo_count = 10'd64; rd_enable = 1'b1; rfifo_count = '0;
    for (int k = 0; k < 6; k++) begin
      predict(eg, ea);
      do_burst(0, 0, got, og, addr, lat, stable);
      n_cmp++; if (og !== eg || addr !== ea || lat !== 1) begin
        n_bad++; $display("FAIL b2b[%0d] got=%0d@%0d lat=%0d exp=%0d@%0d lat=1", k, og, addr, lat, eg, ea); end
      n_cmp++; if (sdr.sdr_req !== 1'b0) begin
        n_bad++; $display("FAIL b2b_gap[%0d] req=%b exp=0", k, sdr.sdr_req); end
      model_commit(eg, ea);
    end
  endtask

  task automatic test_mid_reset();
    bit got, stable, seen; int og, lat; logic [AW-1:0] addr;
    wfifo_count = 10'd64; rd_enable = 1'b1; rfifo_count = '0;
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (sdr.sdr_req) seen = 1;
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL midrst_grant req_seen=%b exp=1", seen); end
    sdr.sdr_ack = 1'b1;
    @(negedge clk);
    sdr.sdr_ack = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (sdr.sdr_req !== 1'b0 || sdr.sdr_addr !== 24'd0 || sdr.sdr_wr !== 1'b0) begin
      n_bad++; $display("FAIL midrst_bus got=%b/%0d/%b exp=0/0/0", sdr.sdr_req, sdr.sdr_addr, sdr.sdr_wr); end
    n_cmp++; if (ring_level !== 3'd0 || ring_empty !== 1'b1 || ring_full !== 1'b0) begin
      n_bad++; $display("FAIL midrst_ring got=%0d/%b/%b exp=0/1/0", ring_level, ring_empty, ring_full); end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    do_burst(0, 1, got, og, addr, lat, stable);
    n_cmp++; if (og !== 1 || addr !== 24'd0) begin n_bad++; $display("FAIL midrst_restart got=%0d@%0d exp=1@0", og, addr); end
    model_commit(1, 24'd0);
  endtask

  task automatic test_random();
    bit got, stable, seen; int og, lat, eg; logic [AW-1:0] addr, ea;
    apply_reset();
    for (int it = 0; it < 120; it++) begin
      init_done = ($urandom_range(0, 9) != 0);
      rd_enable = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: wfifo_count = CW'(BL - 1);
        1: wfifo_count = CW'(BL);
        2: wfifo_count = CW'($urandom_range(0, 1023));
        default: wfifo_count = '0;
      endcase
      case ($urandom_range(0, 3))
        0: rfifo_count = CW'(DEPTH - BL);
        1: rfifo_count = CW'(DEPTH - BL + 1);
        2: rfifo_count = CW'($urandom_range(0, DEPTH));
        default: rfifo_count = '0;
      endcase
      predict(eg, ea);
      if (eg == 0) begin
        idle_cycles(3, seen);
        og = seen ? 9 : 0;
        addr = '0; lat = 1; stable = 1;
      end else begin
        do_burst($urandom_range(0, 3), $urandom_range(0, 3), got, og, addr, lat, stable);
      end
      n_cmp++; if (og !== eg) begin n_bad++; $display("FAIL rnd_grant it=%0d got=%0d exp=%0d", it, og, eg); end
      if (eg != 0) begin
        n_cmp++; if (addr !== ea || lat !== 1 || stable !== 1'b1) begin
          n_bad++; $display("FAIL rnd_burst it=%0d addr=%0d lat=%0d hold=%b exp addr=%0d lat=1 hold=1",
                            it, addr, lat, stable, ea); end
      end
      model_commit(eg, ea);
      n_cmp++; if (ring_level !== 3'(ring_q.size()) || ring_full !== (ring_q.size() == RING) ||
                   ring_empty !== (ring_q.size() == 0)) begin
        n_bad++; $display("FAIL rnd_ring it=%0d got=%0d/%b/%b exp=%0d", it, ring_level, ring_full, ring_empty, ring_q.size()); end
    end
  endtask

  task automatic test_timeout();
    bit seen;
    apply_reset();
    init_done = 1'b1; wfifo_count = 10'd8; rd_enable = 1'b0;
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (sdr.sdr_req) seen = 1;
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL tmo_grant req_seen=%b exp=1", seen); end
    sdr.sdr_ack = 1'b1;
    @(negedge clk);
    sdr.sdr_ack = 1'b0;
    wfifo_count = '0;
    repeat (TMO + 3) @(negedge clk);
`ifdef SDRAM_ARB_TIMEOUT_EN
    n_cmp++; if (err !== 1'b1 || ring_level !== 3'd0 || sdr.sdr_req !== 1'b0) begin
      n_bad++; $display("FAIL tmo_err got err=%b lvl=%0d req=%b exp 1/0/0", err, ring_level, sdr.sdr_req); end
    wfifo_count = 10'd8;
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (sdr.sdr_req) seen = 1;
    end
    n_cmp++; if (seen !== 1'b1 || sdr.sdr_addr !== 24'd0) begin
      n_bad++; $display("FAIL tmo_retry got req=%b addr=%0d exp 1/0", seen, sdr.sdr_addr); end
`else
    n_cmp++; if (err !== 1'b0 || ring_level !== 3'd0) begin
      n_bad++; $display("FAIL tmo_wait got err=%b lvl=%0d exp 0/0", err, ring_level); end
    sdr.sdr_done = 1'b1;
    @(negedge clk);
    sdr.sdr_done = 1'b0;
    n_cmp++; if (ring_level !== 3'd1 || err !== 1'b0) begin
      n_bad++; $display("FAIL tmo_late_done got lvl=%0d err=%b exp 1/0", ring_level, err); end
`endif
  endtask

  initial begin
    test_reset();
    test_init_gate();
    test_single_write();
    test_contention();
    test_wrap_full();
    test_read_gating();
    test_back_to_back();
    test_mid_reset();
    test_random();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached compared=%0d", n_cmp);
    $fatal(1, "time limit");
  end

endmodule
